// File: rtl/seven_seg_driver_pkg.sv
// Shared constants for the seven-segment display stage: segment codes,
// converter state encoding and the largest displayable value.
package seven_seg_driver_pkg;

    localparam logic [13:0] BCD_MAX = 14'd9999;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } conv_state_t;

    // Active-low cathode patterns, bit order g..a
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/seven_seg_driver_if.sv
// Value/decimal-point request in, multiplexed display drive and busy out.
interface seven_seg_driver_if;
    logic [13:0] display_value;
    logic        dp;
    logic [6:0]  seg;
    logic        dp_n;
    logic [3:0]  an;
    logic        busy;

    modport master (output display_value, dp, input seg, dp_n, an, busy);
    modport slave  (input display_value, dp, output seg, dp_n, an, busy);
endinterface

// File: rtl/seven_seg_driver_bin2bcd_seq.sv
// Sequential double-dabble converter. Holds the committed BCD digits and
// the raw value they came from, so the caller can detect a new input.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | waiting for start; display digits stable
// ST_SHIFT  | 14 adjust-and-shift iterations on the clamped value
// ST_COMMIT | publish all four digits at once, record the raw input
module bin2bcd_seq
    import seven_seg_driver_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [13:0] bin_in,
    output logic        busy,
    output logic [15:0] bcd,
    output logic [13:0] last_value
);

    conv_state_t state;
    logic [13:0] shift_reg;
    logic [13:0] raw_value;
    logic [15:0] acc;
    logic [15:0] acc_adj;
    logic [3:0]  iter;

    // Add 3 to every nibble of 5 or more before the next shift
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < 4; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
    end

    // Converter FSM; reset abandons any conversion in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            shift_reg  <= '0;
            raw_value  <= '0;
            acc        <= '0;
            iter       <= '0;
            busy       <= 1'b0;
            bcd        <= '0;
            last_value <= 14'h3FFF;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shift_reg <= (bin_in > BCD_MAX) ? BCD_MAX : bin_in;
                        raw_value <= bin_in;
                        acc       <= '0;
                        iter      <= '0;
                        busy      <= 1'b1;
                        state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    acc       <= (acc_adj << 1) | {15'd0, shift_reg[13]};
                    shift_reg <= shift_reg << 1;
                    iter      <= iter + 4'd1;
                    if (iter == 4'd13) begin
                        state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    bcd        <= acc;
                    last_value <= raw_value;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/seven_seg_driver.sv
// Four-digit multiplexed seven-segment driver: converts the binary value
// to BCD, blanks leading zeros and scans the anodes at a divided rate.
module seven_seg_driver
    import seven_seg_driver_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int DP_DIGIT    = 1
) (
    input  logic               clk100Mhz,
    input  logic               rst,
    seven_seg_driver_if.slave  bus
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [15:0]      bcd;
    logic [13:0]      last_value;
    logic             conv_busy;
    logic             start;
    logic [CNT_W-1:0] refresh_cnt;
    logic [1:0]       digit_idx;
    logic [3:0]       cur_nib;
    logic             lead_zero;
    logic             keep_digit;
    logic             dp_hit;
    logic [6:0]       seg_next;

    // A mismatch is only acted on while the converter is idle
    assign start    = (bus.display_value != last_value);
    assign bus.busy = conv_busy;

    bin2bcd_seq u_bin2bcd (
        .clk        (clk100Mhz),
        .rst        (rst),
        .start      (start),
        .bin_in     (bus.display_value),
        .busy       (conv_busy),
        .bcd        (bcd),
        .last_value (last_value)
    );

    // Digit select, leading-zero blanking and decimal-point match
    always_comb begin
        cur_nib = bcd[{digit_idx, 2'b00} +: 4];
        case (digit_idx)
            2'd0:    lead_zero = 1'b0;
            2'd1:    lead_zero = (bcd[15:4] == 12'd0);
            2'd2:    lead_zero = (bcd[15:8] == 8'd0);
            default: lead_zero = (bcd[15:12] == 4'd0);
        endcase
        keep_digit = bus.dp && (int'(digit_idx) <= DP_DIGIT);
        dp_hit     = bus.dp && (int'(digit_idx) == DP_DIGIT);
        seg_next   = (lead_zero && !keep_digit) ? SEG_BLANK : seg_decode(cur_nib);
    end

    // Refresh divider and registered display drive; an/seg/dp_n move together
    always_ff @(posedge clk100Mhz) begin
        if (rst) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
            bus.seg     <= SEG_BLANK;
            bus.dp_n    <= 1'b1;
            bus.an      <= 4'hF;
        end else begin
            bus.seg  <= seg_next;
            bus.dp_n <= !dp_hit;
            bus.an   <= ~(4'b0001 << digit_idx);
            if (refresh_cnt == CNT_LAST) begin
                refresh_cnt <= '0;
                digit_idx   <= digit_idx + 2'd1;
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_driver.sv
// Directed plus randomized bench for seven_seg_driver with a decimal
// reference model for the expected digits, blanking and decimal point.
module tb_seven_seg_driver;

    localparam int DP_DIGIT = 1;
    localparam logic [6:0] SEG_TBL [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    seven_seg_driver_if bus ();

    seven_seg_driver #(.REFRESH_DIV(4), .DP_DIGIT(DP_DIGIT)) dut (
        .clk100Mhz (clk),
        .rst       (rst),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected cathodes for digit k of value v, from decimal arithmetic
    function automatic logic [6:0] exp_seg(input int v, input bit dpv, input int k);
        int vc, p, d;
        vc = (v > 9999) ? 9999 : v;
        p  = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        d = (vc / p) % 10;
        if (k != 0 && vc < p && !(dpv && k <= DP_DIGIT)) return 7'h7F;
        return SEG_TBL[d];
    endfunction

    function automatic int an_index(input logic [3:0] a);
        for (int k = 0; k < 4; k++) begin
            if (a === ~(4'b0001 << k)) return k;
        end
        return -1;
    endfunction

    // Wait (bounded) for busy, then return how many cycles it stayed high
    task automatic busy_run(input string tag);
        int t, len;
        t = 0;
        len = 0;
        while (bus.busy !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        while (bus.busy === 1'b1 && len < 40) begin
            len++;
            @(negedge clk);
        end
        check(tag, len, 15);
    endtask

    // Watch four full digit periods: digit contents and scan order
    task automatic scan_check(input int v, input bit dpv, input string tag);
        int k, kp;
        kp = -1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            k = an_index(bus.an);
            check({tag, "_an_onehot"}, (k >= 0) ? 1 : 0, 1);
            if (k >= 0) begin
                if (kp >= 0 && k != kp) check({tag, "_an_order"}, k, (kp + 1) % 4);
                check({tag, "_seg"}, bus.seg, exp_seg(v, dpv, k));
                check({tag, "_dp_n"}, bus.dp_n, (dpv && k == DP_DIGIT) ? 0 : 1);
                kp = k;
            end
        end
    endtask

    int  s, t, k, r1, g, r2, idx, v, last_v;
    bit  dpv, ok;
    logic bh [64];

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.display_value = 14'd1234;
        bus.dp = 1'b0;

        // Reset and first conversion
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("rst_an", bus.an, 4'hF);
        check("rst_seg", bus.seg, 7'h7F);
        check("rst_dp_n", bus.dp_n, 1);
        check("rst_busy", bus.busy, 0);
        rst = 1'b0;
        busy_run("first_busy");
        scan_check(1234, 0, "first");

        // Clamp
        bus.display_value = 14'h3FFF;
        busy_run("clamp_busy");
        scan_check(16383, 0, "clamp");

        // Leading-zero blanking
        bus.display_value = 14'd7;
        busy_run("blank_busy");
        scan_check(7, 0, "blank");

        // Decimal point keeps digit 1 lit
        bus.display_value = 14'd5;
        bus.dp = 1'b1;
        busy_run("dp_busy");
        scan_check(5, 1, "dp");

        // Input change mid-conversion
        bus.dp = 1'b0;
        bus.display_value = 14'd1234;
        s = -1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            bh[i] = bus.busy;
            if (s < 0 && bus.busy === 1'b1) s = i;
            if (s >= 0 && i == s + 5) bus.display_value = 14'd5678;
            k = an_index(bus.an);
            ok = (k >= 0) && (bus.seg === exp_seg(5, 0, k) || bus.seg === exp_seg(1234, 0, k) ||
                              bus.seg === exp_seg(5678, 0, k));
            check("mid_no_glitch", ok, 1);
        end
        r1 = 0; g = 0; r2 = 0;
        idx = (s < 0) ? 64 : s;
        while (idx < 64 && bh[idx] === 1'b1) begin r1++; idx++; end
        while (idx < 64 && bh[idx] !== 1'b1) begin g++; idx++; end
        while (idx < 64 && bh[idx] === 1'b1) begin r2++; idx++; end
        check("mid_run1", r1, 15);
        check("mid_gap", g, 1);
        check("mid_run2", r2, 15);
        scan_check(5678, 0, "mid_final");

        // Reset during SHIFT iteration 7
        bus.display_value = 14'd4321;
        t = 0;
        while (bus.busy !== 1'b1 && t < 40) begin @(negedge clk); t++; end
        check("rstmid_start", bus.busy, 1);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_an", bus.an, 4'hF);
        check("rstmid_seg", bus.seg, 7'h7F);
        check("rstmid_dp_n", bus.dp_n, 1);
        check("rstmid_busy", bus.busy, 0);
        rst = 1'b0;
        busy_run("rstmid_busy_run");
        scan_check(4321, 0, "rstmid");

        // Randomized values and decimal point
        last_v = 4321;
        for (int n = 0; n < 8; n++) begin
            v = int'($urandom_range(0, 16383));
            if (v == last_v) v = (v + 1) % 16384;
            dpv = 1'($urandom_range(0, 1));
            bus.display_value = 14'(v);
            bus.dp = dpv;
            busy_run("rand_busy");
            scan_check(v, dpv, "rand");
            last_v = v;
        end

        // Decimal point toggle needs no conversion
        bus.dp = ~dpv;
        scan_check(last_v, ~dpv, "dp_toggle");
        check("dp_toggle_busy", bus.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_seg_driver.md
Name: seven_seg_driver

Overview:
- Downstream display stage: consumes the rotated `display_value`/`dp` pair and drives the 4-digit multiplexed seven-segment display.
- Converts the 14-bit binary value to BCD with a sequential shift-add-3 (double-dabble) engine.
- Blanks leading zeros and time-multiplexes the anodes at a divided refresh rate from `clk100Mhz`.

Parameters:
- `REFRESH_DIV`, default 100000: clock cycles each digit stays lit (1 kHz digit rate at 100 MHz).
- `DP_DIGIT`, default 1: digit index (0 = rightmost) whose decimal point follows `dp`.

Ports:
- `clk100Mhz`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `display_value`  in  14  binary value to show; 0..9999 valid, larger values clamp
- `dp`  in  1  decimal-point request
- `seg`  out  7  cathodes, active-low; `seg[0]`=a .. `seg[6]`=g
- `dp_n`  out  1  decimal-point cathode, active-low
- `an`  out  4  anodes, active-low, one-hot; `an[0]` = rightmost digit
- `busy`  out  1  high while a conversion is in progress

Behaviour:
- Reset (sync, priority over all else):
  - `seg`=7'h7F, `dp_n`=1, `an`=4'hF, `busy`=0.
  - BCD display registers = 0, digit index = 0, refresh counter = 0.
  - Converter state = IDLE; last-converted register = 14'h3FFF, so the first compare mismatches.
- Converter FSM: IDLE -> SHIFT -> COMMIT -> IDLE.
  - IDLE: when `display_value` != last-converted, latch the clamped value (>9999 becomes 9999) into the shift register, clear the 16-bit BCD accumulator, set `busy`=1, go to SHIFT.
  - SHIFT: exactly 14 cycles. Each cycle, add 3 to every BCD nibble that is >=5, then shift left by one, feeding in the binary MSB. A 4-bit iteration counter counts 0..13.
  - COMMIT: 1 cycle. Copy all four BCD nibbles atomically into the display registers, record last-converted = the latched unclamped input, clear `busy`, return to IDLE.
  - Latency: input change to display registers = 16 cycles (capture + 14 + commit).
- Input changes during SHIFT/COMMIT are ignored. IDLE re-compares on the next cycle, so the newest value is converted within at most 32 cycles of its last change.
- `dp` is not converted. It is sampled combinationally during scan, so it has no conversion latency.
- Scan:
  - The refresh counter counts 0..`REFRESH_DIV`-1. On wrap, the digit index increments 0->1->2->3->0.
  - `an` drives low only the bit at the digit index.
  - `seg` and `dp_n` are registered together with `an`, so all three change on the same edge.
- Leading-zero blanking:
  - Digit k (k=3..1) is blank (`seg`=7'h7F) when it and all higher digits are 0.
  - Digit 0 is never blanked.
  - When `dp`=1, digits with index <= `DP_DIGIT` are never blanked.
- Decimal point: `dp_n`=0 only when the scanned digit == `DP_DIGIT` and `dp`=1.
- Segment codes, 0..9 = 40,79,24,30,19,12,02,78,00,10 (hex, g..a); blank = 7F.
- Reset mid-conversion aborts the conversion. The display registers return to 0, and a fresh conversion starts the cycle after `rst` falls.

Decomposition:
- Shared package/include holds:
  - the segment-code constants;
  - FSM state encodings (IDLE=0, SHIFT=1, COMMIT=2);
  - the `BCD_MAX` = 9999 constant.
- Sub-module `bin2bcd_seq` (converter FSM with start/busy/done and a 16-bit BCD output) is natural. Scan mux and blanking stay in the top.

Test Plan:
- Simulation uses `REFRESH_DIV`=4.
- Reset/first value: hold `rst` 10 cycles with `display_value`=1234, `dp`=0 -> during reset `an`=F, `seg`=7F. After release, `busy` is high 15 cycles then low. Scan shows: `an`=E `seg`=19 (4), `an`=D `seg`=30 (3), `an`=B `seg`=24 (2), `an`=7 `seg`=79 (1). `dp_n`=1 throughout.
- Clamp: `display_value`=14'h3FFF -> all four digits show `seg`=10 (9999).
- Blanking: `display_value`=7, `dp`=0 -> digits 3..1 show `seg`=7F, digit 0 shows `seg`=78.
- Decimal point: `display_value`=5, `dp`=1, `DP_DIGIT`=1 -> digit 1 shows `seg`=40 with `dp_n`=0, digit 0 shows `seg`=12, digits 3..2 blank.
- Mid-conversion change: 1234, then 5678 five cycles after the conversion starts -> 1234 commits at cycle 16. `busy` reasserts the next cycle and 5678 commits by cycle 32. No intermediate value ever appears on `seg`.
- Reset mid-SHIFT: assert `rst` at iteration 7 for 1 cycle -> outputs return to reset values. The current value is reconverted and displayed 16 cycles after release.
